dram_arbiter: RTL
=================

Name: dram_arbiter

Overview:
- Shares the single DRAM port (the level-enable interface in front of the AXI adapter) between NREQ requesters, e.g. the DMA controller, an instruction fetcher and a host debug port.
- Arbitration is round-robin. A grant is held for one whole transaction, until dramValid is seen.
- Returns read data and a one-cycle completion pulse to the granted requester.
- Sits between the requesters and the DRAM adapter.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- TIMEOUT, 1024, cycles to wait for dramValid before aborting. Used only when DRAM_ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- reqAddress  input  NREQ x 32  per-requester byte address
- reqWriteData  input  NREQ x 32  per-requester write data
- reqReadEnable  input  NREQ  per-requester read request, level
- reqWriteEnable  input  NREQ  per-requester write request, level
- reqValid  output  NREQ  one-cycle completion pulse, one-hot
- reqReadData  output  32  read data; meaningful while reqValid is high
- reqError  output  1  abort flag, qualified by reqValid
- grant  output  NREQ  one-hot current owner; 0 when idle
- dramAddress  output  32  to adapter
- dramWriteData  output  32  to adapter
- dramReadEnable  output  1  to adapter
- dramWriteEnable  output  1  to adapter
- dramReadData  input  32  from adapter
- dramValid  input  1  from adapter; transaction done in this cycle

Behaviour:
- Reset: all outputs are 0. State goes to IDLE. The round-robin pointer is set so requester 0 has highest priority. The reset is asynchronous, so DRAM enables drop immediately even mid-transaction. No reqValid is issued for an aborted transaction.
- A requester is "requesting" when reqReadEnable[i] or reqWriteEnable[i] is high. It must hold its enables and its address/data stable until the cycle after it samples reqValid[i] high, then deassert.
- State IDLE:
  - grant is 0 and DRAM enables are 0.
  - If any requester is requesting, pick the first requesting index after the last granted index, wrapping modulo NREQ.
  - Register grant, address, data and op. If both enables are high, the op is write; a bench assertion flags this.
  - Go to BUSY.
- State BUSY:
  - dramAddress and dramWriteData come from the latched values.
  - Exactly one of dramReadEnable/dramWriteEnable is high, driven from a register (not combinationally from the requester).
  - When dramValid is high: capture dramReadData into reqReadData (reads only; writes leave it unchanged), then go to RESP.
  - Without dramValid, stay in BUSY.
- State RESP:
  - DRAM enables are 0.
  - reqValid[granted] is 1 for exactly this cycle.
  - Update the last-granted pointer, clear grant, go to IDLE.
  - IDLE does not sample in this cycle, so a still-held request cannot be re-granted.
- Latency: request seen in IDLE at cycle 0. If dramValid arrives in the first BUSY cycle (cycle 1), reqValid is high in cycle 2. In general, reqValid comes 2 + (BUSY wait cycles - 1) cycles after the request.
- Minimum spacing between grants is 3 cycles (IDLE, BUSY, RESP).
- Fairness: with all NREQ requesting continuously, each is served once per NREQ transactions. No requester waits more than NREQ-1 transactions.
- A request arriving mid-transaction waits; it is never dropped.
- dramValid outside BUSY is ignored.
- Requests change only at IDLE boundaries; inputs in BUSY/RESP have no effect except the latched ones.

Optional Feature:
- Macro: DRAM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter of width clog2(TIMEOUT+1) clears on BUSY entry and increments each BUSY cycle without dramValid.
  - When it reaches TIMEOUT, drop the DRAM enables and go to RESP with reqError=1 and reqReadData=32'hDEADBEEF.
  - dramValid and timeout in the same cycle count as success.
  - A sticky timeoutSeen flag is kept internally, cleared only by reset.
- Undefined: BUSY waits indefinitely, and reqError is tied to 0.

Test Plan:
- Single read: requester 0 reads 0x1000; adapter model asserts dramValid with 0xCAFEF00D in the first BUSY cycle → reqValid[0] in cycle 2 with reqReadData=0xCAFEF00D; grant = 01 only during BUSY/RESP.
- Contention: requester 0 writes 0x2000 and requester 1 reads 0x3000 in the same cycle after reset → requester 0 served first, then requester 1; every dramValid is 3 wait cycles late; exactly one reqValid per requester and no double grant.
- Round robin: both requesters hold requests for 6 transactions → grant order 0,1,0,1,0,1; dramWriteData equals the granted requester's data.
- Wait states: dramValid delayed 10 cycles → DRAM enables held constant for 10 BUSY cycles; address is stable even though the non-granted requester's inputs toggle.
- Reset mid-BUSY: assert reset in cycle 5 of a read → dramReadEnable=0 asynchronously, no reqValid; after release, requester 0 has priority.
- DRAM_ARB_TIMEOUT_EN with TIMEOUT=16 and dramValid never asserted → after 16 BUSY cycles, reqValid with reqError=1 and reqReadData=0xDEADBEEF; the next request is served normally.

Source files
------------

// File: rtl/dram_arbiter_if.sv
// Requester-side and DRAM-adapter-side signals of dram_arbiter.
// master: the arbiter; slave: the requesters and the DRAM adapter.
interface dram_arbiter_if #(
   parameter int unsigned NREQ = 2
);
   localparam int unsigned DW = 32;

   logic [NREQ-1:0][DW-1:0] reqAddress;
   logic [NREQ-1:0][DW-1:0] reqWriteData;
   logic [NREQ-1:0]         reqReadEnable;
   logic [NREQ-1:0]         reqWriteEnable;
   logic [NREQ-1:0]         reqValid;
   logic [DW-1:0]           reqReadData;
   logic                    reqError;
   logic [NREQ-1:0]         grant;
   logic [DW-1:0]           dramAddress;
   logic [DW-1:0]           dramWriteData;
   logic                    dramReadEnable;
   logic                    dramWriteEnable;
   logic [DW-1:0]           dramReadData;
   logic                    dramValid;

   modport master (
      input  reqAddress, reqWriteData, reqReadEnable, reqWriteEnable,
      input  dramReadData, dramValid,
      output reqValid, reqReadData, reqError, grant,
      output dramAddress, dramWriteData, dramReadEnable, dramWriteEnable
   );

   modport slave (
      output reqAddress, reqWriteData, reqReadEnable, reqWriteEnable,
      output dramReadData, dramValid,
      input  reqValid, reqReadData, reqError, grant,
      input  dramAddress, dramWriteData, dramReadEnable, dramWriteEnable
   );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM port between NREQ requesters; grant held per transaction.
// Optional DRAM_ARB_TIMEOUT_EN aborts a transaction after TIMEOUT BUSY cycles without dramValid.
module dram_arbiter #(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned TIMEOUT = 1024
) (
   input logic            clk,
   input logic            reset,
   dram_arbiter_if.master bus
);
   localparam int unsigned DW   = 32;
   localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1) begin : g_bad_param
      $error("dram_arbiter: NREQ must be 2..4 and TIMEOUT at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP
   } state_e;

   state_e            state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   valid_q, valid_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [IDXW-1:0]   last_q, last_d;
   logic [DW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;

   logic [NREQ-1:0]   requesting;
   logic              pick_found;
   logic [IDXW-1:0]   pick_idx;

`ifdef DRAM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W      = $clog2(TIMEOUT + 1);
   localparam logic [DW-1:0] ABORT_DATA = 32'hDEAD_BEEF;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              timeoutSeen_q, timeoutSeen_d;
`endif

   assign requesting = bus.reqReadEnable | bus.reqWriteEnable;

   // First requester after the last-granted index, wrapping modulo NREQ.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         if (!pick_found && requesting[IDXW'((32'(last_q) + off) % NREQ)]) begin
            pick_found = 1'b1;
            pick_idx   = IDXW'((32'(last_q) + off) % NREQ);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      valid_d = '0;
      idx_d   = idx_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
`ifdef DRAM_ARB_TIMEOUT_EN
      cnt_d         = cnt_q;
      err_d         = 1'b0;
      timeoutSeen_d = timeoutSeen_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               idx_d   = pick_idx;
               grant_d = NREQ'(1) << pick_idx;
               addr_d  = bus.reqAddress[pick_idx];
               wdata_d = bus.reqWriteData[pick_idx];
               // Both enables high resolves to a write.
               wr_d    = bus.reqWriteEnable[pick_idx];
               rd_d    = !bus.reqWriteEnable[pick_idx];
`ifdef DRAM_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (bus.dramValid) begin
               if (rd_q) rdata_d = bus.dramReadData;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               valid_d = grant_q;
               state_d = S_RESP;
            end
`ifdef DRAM_ARB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(TIMEOUT)) begin
                  rdata_d       = ABORT_DATA;
                  rd_d          = 1'b0;
                  wr_d          = 1'b0;
                  valid_d       = grant_q;
                  err_d         = 1'b1;
                  timeoutSeen_d = 1'b1;
                  state_d       = S_RESP;
               end
            end
`endif
         end
         S_RESP: begin
            last_d  = idx_q;
            grant_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         valid_q <= '0;
         idx_q   <= '0;
         last_q  <= IDXW'(NREQ - 1);
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

`ifdef DRAM_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q         <= '0;
         err_q         <= 1'b0;
         timeoutSeen_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         err_q         <= err_d;
         timeoutSeen_q <= timeoutSeen_d;
      end
   end

   assign bus.reqError = err_q;
`else
   assign bus.reqError = 1'b0;
`endif

   assign bus.grant           = grant_q;
   assign bus.reqValid        = valid_q;
   assign bus.reqReadData     = rdata_q;
   assign bus.dramAddress     = addr_q;
   assign bus.dramWriteData   = wdata_q;
   assign bus.dramReadEnable  = rd_q;
   assign bus.dramWriteEnable = wr_q;
endmodule
